i2s_mic_array: RTL and testbench

Parametrised multi-microphone I2S receiver for the `audio_clk` domain (98.304 MHz). One shared BCLK and one shared LRCL drive every mic in the array. The block captures the left-slot word of each mic in lockstep and presents all channels as one frame through a valid/ready handshake. It sits between the PMOD mic pins and the anti-aliasing and distance-estimation pipeline, and replaces per-mic receivers that each generate their own clocks.

---
 rtl/i2s_mic_array.sv | 159 +++++++++++++++
 tb/tb_i2s_mic_array.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_mic_array.sv
// Shared-clock multi-mic I2S receiver: left-slot words of all mics captured in lockstep, one frame out via valid/ready.
// Optional per-channel DC-blocking stage when I2S_DC_BLOCK_EN is defined (adds one cycle of latency).
`timescale 1ns/1ps
module i2s_mic_array #(
  parameter int NUM_MICS     = 3,
  parameter int MIC_BITS     = 24,
  parameter int SAMPLE_WIDTH = 16,
  parameter int BCLK_DIV     = 32,
  parameter int DC_SHIFT     = 10
) (
  input  logic                             audio_clk,
  input  logic                             rst_in,
  input  logic [NUM_MICS-1:0]              mic_data_in,
  output logic                             bclk_out,
  output logic                             lrcl_out,
  output logic [NUM_MICS*SAMPLE_WIDTH-1:0] samples_out,
  output logic                             valid_out,
  input  logic                             ready_in,
  output logic                             overflow_out,
  input  logic                             clear_overflow_in
);
  localparam int DW = $clog2(BCLK_DIV);
  localparam logic [DW-1:0] DIV_HALF = DW'(BCLK_DIV / 2);
  localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);
  localparam logic [5:0]    LAST_BIT = 6'(MIC_BITS);

  typedef logic [NUM_MICS-1:0][MIC_BITS-1:0]     shift_t;
  typedef logic [NUM_MICS-1:0][SAMPLE_WIDTH-1:0] frame_t;

  if (MIC_BITS > 31 || MIC_BITS < 2 || SAMPLE_WIDTH > MIC_BITS || BCLK_DIV < 4 ||
      (BCLK_DIV % 2) != 0 || DC_SHIFT < 1) begin : g_param_check
    $error("i2s_mic_array: illegal parameter combination");
  end

  logic [DW-1:0] div_q, div_d;
  logic [5:0]    bit_q, bit_d;
  logic          bclk_q, bclk_d;
  logic          lrcl_q, lrcl_d;
  logic          strobe, capture, frame_done;
  shift_t        shift_q, shift_d;
  frame_t        trunc;
  frame_t        new_dat;
  logic          new_vld;
  frame_t        samples_q, samples_d;
  logic          valid_q, valid_d;
  logic          ovf_q, ovf_d, ovf_set;

  // bit_idx advances together with the divider wrap, i.e. on the BCLK falling edge
  always_comb begin
    div_d  = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    bit_d  = (div_q == DIV_LAST) ? bit_q + 1'b1 : bit_q;
    bclk_d = (div_d >= DIV_HALF);
    lrcl_d = bit_q[5];
  end

  assign strobe     = (div_q == DIV_HALF);
  assign capture    = strobe && (bit_q != 6'd0) && (bit_q <= LAST_BIT);
  assign frame_done = strobe && (bit_q == LAST_BIT);

  always_comb begin
    shift_d = shift_q;
    trunc   = '0;
    for (int i = 0; i < NUM_MICS; i++) begin
      if (capture) shift_d[i] = {shift_q[i][MIC_BITS-2:0], mic_data_in[i]};
      trunc[i] = shift_d[i][MIC_BITS-1 -: SAMPLE_WIDTH];
    end
  end

`ifdef I2S_DC_BLOCK_EN
  localparam int AW = SAMPLE_WIDTH + 2;
  localparam logic signed [AW-1:0] SAT_MAX = {3'b000, {(SAMPLE_WIDTH-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {3'b111, {(SAMPLE_WIDTH-1){1'b0}}};

  frame_t               xprev_q, xprev_d;
  frame_t               yprev_q, yprev_d;
  logic                 filt_vld_q;
  logic signed [AW-1:0] acc [NUM_MICS];

  // y_prev holds the saturated output, so it doubles as this stage's output register
  always_comb begin
    xprev_d = xprev_q;
    yprev_d = yprev_q;
    acc     = '{default: '0};
    for (int i = 0; i < NUM_MICS; i++) begin
      acc[i] = AW'($signed(trunc[i])) - AW'($signed(xprev_q[i])) + AW'($signed(yprev_q[i]))
             - (AW'($signed(yprev_q[i])) >>> DC_SHIFT);
      if (frame_done) begin
        xprev_d[i] = trunc[i];
        if (acc[i] > SAT_MAX)      yprev_d[i] = SAMPLE_WIDTH'(SAT_MAX);
        else if (acc[i] < SAT_MIN) yprev_d[i] = SAMPLE_WIDTH'(SAT_MIN);
        else                       yprev_d[i] = acc[i][SAMPLE_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge audio_clk) begin
    if (rst_in) begin
      xprev_q    <= '0;
      yprev_q    <= '0;
      filt_vld_q <= 1'b0;
    end else begin
      xprev_q    <= xprev_d;
      yprev_q    <= yprev_d;
      filt_vld_q <= frame_done;
    end
  end

  assign new_vld = filt_vld_q;
  assign new_dat = yprev_q;
`else
  assign new_vld = frame_done;
  assign new_dat = trunc;
`endif

  // A frame arriving while the previous one is still unaccepted is dropped; set beats clear
  always_comb begin
    samples_d = samples_q;
    valid_d   = valid_q;
    ovf_set   = 1'b0;
    if (valid_q && ready_in) valid_d = 1'b0;
    if (new_vld) begin
      if (!valid_q || ready_in) begin
        samples_d = new_dat;
        valid_d   = 1'b1;
      end else begin
        ovf_set = 1'b1;
      end
    end
    ovf_d = ovf_set || (ovf_q && !clear_overflow_in);
  end

  always_ff @(posedge audio_clk) begin
    if (rst_in) begin
      div_q     <= '0;
      bit_q     <= '0;
      bclk_q    <= 1'b0;
      lrcl_q    <= 1'b0;
      shift_q   <= '0;
      samples_q <= '0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      div_q     <= div_d;
      bit_q     <= bit_d;
      bclk_q    <= bclk_d;
      lrcl_q    <= lrcl_d;
      shift_q   <= shift_d;
      samples_q <= samples_d;
      valid_q   <= valid_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bclk_out     = bclk_q;
  assign lrcl_out     = lrcl_q;
  assign samples_out  = samples_q;
  assign valid_out    = valid_q;
  assign overflow_out = ovf_q;
endmodule

// File: tb/tb_i2s_mic_array.sv
// Randomized bench for i2s_mic_array: cycle-indexed I2S mic models plus a frame-level reference model.
`timescale 1ns/1ps
module tb_i2s_mic_array;
  localparam int NM        = 3;
  localparam int MB        = 24;
  localparam int SW        = 16;
  localparam int DIV       = 32;
  localparam int FRAME     = 64 * DIV;
  localparam int DONE_POS  = MB * DIV + DIV / 2;
`ifdef I2S_DC_BLOCK_EN
  localparam int LAT       = 2;
  localparam int DC_SHIFT  = 10;
  localparam int SMAX      = (1 << (SW - 1)) - 1;
  localparam int SMIN      = -(1 << (SW - 1));
`else
  localparam int LAT       = 1;
`endif
  localparam int VALID_POS = DONE_POS + LAT;

  logic                 audio_clk = 1'b0;
  logic                 rst_in;
  logic [NM-1:0]        mic_data_in;
  logic                 bclk_out;
  logic                 lrcl_out;
  logic [NM*SW-1:0]     samples_out;
  logic                 valid_out;
  logic                 ready_in;
  logic                 overflow_out;
  logic                 clear_overflow_in;

  logic [MB-1:0]        words [NM];
  logic [NM*SW-1:0]     exp_q [$];
  int                   cyc = 0;
  int                   n_chk = 0;
  int                   n_err = 0;
  int                   mon_bad = 0;
  int                   mon_n = 0;
`ifdef I2S_DC_BLOCK_EN
  int                   xp [NM];
  int                   yp [NM];
`endif

  i2s_mic_array #(
    .NUM_MICS(NM), .MIC_BITS(MB), .SAMPLE_WIDTH(SW), .BCLK_DIV(DIV), .DC_SHIFT(10)
  ) dut (
    .audio_clk(audio_clk), .rst_in(rst_in), .mic_data_in(mic_data_in),
    .bclk_out(bclk_out), .lrcl_out(lrcl_out), .samples_out(samples_out),
    .valid_out(valid_out), .ready_in(ready_in), .overflow_out(overflow_out),
    .clear_overflow_in(clear_overflow_in)
  );

  always #5 audio_clk = ~audio_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Expected output of one completed frame, from the mic words and the filter recurrence
  function automatic logic [NM*SW-1:0] model_frame();
    logic [NM*SW-1:0]    f;
    logic signed [SW-1:0] top;
    int                  x, y;
    f = '0;
    for (int i = 0; i < NM; i++) begin
      top = words[i][MB-1 -: SW];
      x   = top;
      y   = x;
`ifdef I2S_DC_BLOCK_EN
      y = x - xp[i] + yp[i] - (yp[i] >>> DC_SHIFT);
      if (y > SMAX) y = SMAX;
      if (y < SMIN) y = SMIN;
      xp[i] = x;
      yp[i] = y;
`endif
      f[i*SW +: SW] = y[SW-1:0];
    end
    return f;
  endfunction

  // cyc is the index of the current cycle counted from reset release
  always @(posedge audio_clk) begin
    if (rst_in) begin
      cyc <= 0;
      exp_q.delete();
`ifdef I2S_DC_BLOCK_EN
      for (int i = 0; i < NM; i++) begin
        xp[i] = 0;
        yp[i] = 0;
      end
`endif
    end else begin
      cyc <= cyc + 1;
      if (cyc % FRAME == DONE_POS) exp_q.push_back(model_frame());
    end
  end

  // Mics: left-slot bit k (1..MB) carries word bit MB-k; everything else is noise
  initial begin
    logic [NM-1:0] m;
    forever begin
      @(negedge audio_clk);
      for (int i = 0; i < NM; i++) begin
        int k;
        k = (cyc / DIV) % 64;
        if (k >= 1 && k <= MB) m[i] = words[i][MB-k];
        else                   m[i] = 1'($urandom % 2);
      end
      mic_data_in = m;
    end
  end

  initial begin
    forever begin
      @(negedge audio_clk);
      if (cyc >= 1) begin
        mon_n++;
        if (bclk_out !== ((cyc % DIV) >= DIV / 2)) mon_bad++;
        if (lrcl_out !== ((((cyc - 1) / DIV) % 64) >= 32)) mon_bad++;
      end
    end
  end

  function automatic logic [NM*SW-1:0] exp_for(input int c);
    int f;
    f = c / FRAME;
    if (c >= 0 && f < exp_q.size()) return exp_q[f];
    return 'x;
  endfunction

  task automatic new_words();
    for (int i = 0; i < NM; i++) words[i] = MB'($urandom);
  endtask

  task automatic wait_valid(output int c);
    bit seen = 0;
    for (int n = 0; n < FRAME + 200 && !seen; n++) begin
      @(negedge audio_clk);
      if (valid_out === 1'b1) seen = 1;
    end
    check("valid_seen", seen, 1);
    c = seen ? cyc : -1;
  endtask

  task automatic wait_pos(input int p);
    bit hit = 0;
    for (int n = 0; n < FRAME + 8 && !hit; n++) begin
      @(negedge audio_clk);
      if (cyc % FRAME == p) hit = 1;
    end
    check("frame_pos_reached", hit, 1);
  endtask

  initial begin
    int c, ca;
    rst_in = 1'b1;
    ready_in = 1'b0;
    clear_overflow_in = 1'b0;
    mic_data_in = '0;
    words[0] = 24'h7FFF00;
    words[1] = 24'h800100;
    words[2] = 24'h123456;
    repeat (5) @(negedge audio_clk);
    check("rst_valid", valid_out, 0);
    check("rst_samples", samples_out, 0);
    check("rst_ovf", overflow_out, 0);
    check("rst_bclk", bclk_out, 0);
    check("rst_lrcl", lrcl_out, 0);
    rst_in = 1'b0;

    // Capture of the fixed words
    wait_valid(c);
    check("cap_cycle", c, VALID_POS);
    check("cap_model", samples_out, exp_for(c));
    check("cap_literal", samples_out, 48'h1234_8001_7FFF);
    ready_in = 1'b1;
    @(negedge audio_clk);
    check("cap_xfer_drop", valid_out, 0);

    // Streaming with ready held high
    for (int s = 0; s < 4; s++) begin
      wait_pos(1200);
      new_words();
      wait_valid(c);
      check("stream_phase", c % FRAME, VALID_POS);
      check("stream_data", samples_out, exp_for(c));
      @(negedge audio_clk);
      check("stream_pulse", valid_out, 0);
      check("stream_ovf", overflow_out, 0);
    end

    // Backpressure across two completions
    ready_in = 1'b0;
    wait_pos(1200);
    new_words();
    wait_valid(ca);
    check("bp_phase", ca % FRAME, VALID_POS);
    check("bp_first", samples_out, exp_for(ca));
    wait_pos(1200);
    new_words();
    wait_pos(VALID_POS - 1);
    check("bp_ovf_pre", overflow_out, 0);
    clear_overflow_in = 1'b1;
    @(negedge audio_clk);
    clear_overflow_in = 1'b0;
    check("bp_set_wins", overflow_out, 1);
    check("bp_valid_held", valid_out, 1);
    check("bp_held", samples_out, exp_for(ca));
    @(negedge audio_clk);
    clear_overflow_in = 1'b1;
    @(negedge audio_clk);
    clear_overflow_in = 1'b0;
    check("bp_clear", overflow_out, 0);
    ready_in = 1'b1;
    @(negedge audio_clk);
    check("bp_drain", valid_out, 0);
    wait_valid(c);
    check("bp_next_phase", c % FRAME, VALID_POS);
    check("bp_next_frame", c / FRAME, ca / FRAME + 2);
    check("bp_next_data", samples_out, exp_for(c));

    // Reset in the middle of a left slot
    wait_pos(10 * DIV + 10);
    new_words();
    rst_in = 1'b1;
    repeat (3) @(negedge audio_clk);
    check("mid_rst_samples", samples_out, 0);
    check("mid_rst_valid", valid_out, 0);
    rst_in = 1'b0;
    wait_valid(c);
    check("mid_rst_cycle", c, VALID_POS);
    check("mid_rst_data", samples_out, exp_for(c));

    // Constant input: filter step response, or a flat 0x1000 without the filter
    rst_in = 1'b1;
    for (int i = 0; i < NM; i++) words[i] = 24'h100000;
    repeat (3) @(negedge audio_clk);
    rst_in = 1'b0;
    for (int s = 0; s < 4; s++) begin
      wait_valid(c);
      check("dc_data", samples_out, exp_for(c));
      if (s == 0) check("dc_first", samples_out, {NM{16'h1000}});
    end

    check("clk_shape", mon_bad, 0);
    check("clk_observed", mon_n > 1000, 1);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
